// File: rtl/apb_uart_bridge.sv
// APB3/APB4 slave bridging the peripheral bus to one 8N1 UART with TX/RX FIFOs.
// Optional macro APB_UART_SLVERR_EN turns on pslverr for illegal or failed accesses.

module apb_uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module apb_uart_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          FIFO_DEPTH = 16,
    parameter int          baudrate   = 9600,
    parameter int          clk_frec   = 100000000
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        rx,
    output logic        tx,
    input  logic [31:0] paddr,
    input  logic [2:0]  pprot,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr
);
    localparam int DIV  = clk_frec / baudrate;
    localparam int CNTW = $clog2(DIV + 1);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic          access;
    logic [31:0]   offset;
    logic          sel_tx;
    logic          sel_rxs;
    logic          sel_rxd;
    logic          tx_push;
    logic          tx_pop;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_push;
    logic          rx_pop;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic          rx_empty;
    logic          unused_inputs;

    assign unused_inputs = ^{pprot, pstrb, pwdata[31:8]};

    function automatic logic [31:0] status_word(input logic [CW-1:0] cnt);
        logic [31:0] s;
        s = 32'h0;
        if (cnt == CW'(FIFO_DEPTH))          s = 32'h8;
        else if (cnt == CW'(FIFO_DEPTH - 1)) s = 32'h4;
        else if (cnt == '0)                  s = 32'h2;
        else if (cnt == CW'(1))              s = 32'h1;
        return s;
    endfunction

    assign access   = psel && penable;
    assign offset   = paddr - BASE_ADDR;
    assign sel_tx   = (offset == 32'h0);
    assign sel_rxs  = (offset == 32'h4);
    assign sel_rxd  = (offset == 32'h8);
    assign pready   = access;
    assign tx_push  = access && pwrite && sel_tx;
    assign rx_pop   = access && !pwrite && sel_rxd;
    assign rx_empty = (rx_count == '0);

    always_comb begin
        prdata = 32'h0;
        if (access && !pwrite) begin
            if (sel_tx)                   prdata = status_word(tx_count);
            else if (sel_rxs)             prdata = status_word(rx_count);
            else if (sel_rxd && !rx_empty) prdata = {24'h0, rx_head};
        end
    end

`ifdef APB_UART_SLVERR_EN
    logic tx_full;
    assign tx_full = (tx_count == CW'(FIFO_DEPTH));
    assign pslverr = access && (!(sel_tx || sel_rxs || sel_rxd)
                             || (pwrite && (sel_rxs || sel_rxd))
                             || (pwrite && sel_tx && tx_full)
                             || (!pwrite && sel_rxd && rx_empty));
`else
    assign pslverr = 1'b0;
`endif

    apb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .arstn (arstn),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (pwdata[7:0]),
        .rdata (tx_head),
        .count (tx_count)
    );

    // ---------------- transmitter ----------------
    uart_state_t     tx_state;
    uart_state_t     tx_next;
    logic [CNTW-1:0] tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic            tx_bit_end;

    assign tx_bit_end = (tx_cnt == CNTW'(DIV - 1));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    // The stop bit hands over straight to the next start bit when data is waiting.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx      = 1'b1;
        case (tx_state)
            IDLE: begin
                if (tx_count != '0) begin
                    tx_pop  = 1'b1;
                    tx_next = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tx_bit_end) tx_next = DATA;
            end
            DATA: begin
                tx = tx_shift[tx_bit];
                if (tx_bit_end && tx_bit == 3'd7) tx_next = STOP;
            end
            STOP: begin
                if (tx_bit_end) begin
                    if (tx_count != '0) begin
                        tx_pop  = 1'b1;
                        tx_next = START;
                    end else begin
                        tx_next = IDLE;
                    end
                end
            end
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            if (tx_pop) tx_shift <= tx_head;
            if (tx_state == IDLE || tx_bit_end) tx_cnt <= '0;
            else                                tx_cnt <= tx_cnt + CNTW'(1);
            if (tx_state == DATA && tx_bit_end) tx_bit <= tx_bit + 3'd1;
        end
    end

    // ---------------- receiver ----------------
    uart_state_t     rx_state;
    uart_state_t     rx_next;
    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    logic [CNTW-1:0] rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_bit_end;

    assign rx_bit_end = (rx_cnt == CNTW'(DIV - 1));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
        end
    end

    // Start bit is re-checked half a bit in, so every later sample lands mid-bit.
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_s2) rx_next = START;
            end
            START: begin
                if (rx_cnt == CNTW'(DIV / 2 - 1)) rx_next = rx_s2 ? IDLE : DATA;
            end
            DATA: begin
                if (rx_bit_end && rx_bit == 3'd7) rx_next = STOP;
            end
            STOP: begin
                if (rx_bit_end) begin
                    rx_push = rx_s2;
                    rx_next = IDLE;
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == IDLE || rx_next != rx_state || rx_bit_end) rx_cnt <= '0;
            else                                                        rx_cnt <= rx_cnt + CNTW'(1);
            if (rx_state == DATA && rx_bit_end) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    apb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .arstn (arstn),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_shift),
        .rdata (rx_head),
        .count (rx_count)
    );
endmodule

// File: tb/tb_apb_uart_bridge.sv
// Self-checking bench for apb_uart_bridge: randomized APB/UART traffic against a queue-based model.
// Honors APB_UART_SLVERR_EN when predicting pslverr.

module tb_apb_uart_bridge;
    localparam logic [31:0] BASE  = 32'h4000_1000;
    localparam int          DEPTH = 16;
    localparam int          BAUD  = 10;
    localparam int          FREQ  = 160;
    localparam int          DIV   = FREQ / BAUD;
`ifdef APB_UART_SLVERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        arstn   = 1'b0;
    logic        rx      = 1'b1;
    logic        tx;
    logic [31:0] paddr   = 32'h0;
    logic [2:0]  pprot   = 3'h0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] pwdata  = 32'h0;
    logic [3:0]  pstrb   = 4'h0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_got[$];
    logic [7:0] rx_model[$];
    logic [7:0] rx_src[$];
    logic [7:0] tx_exp[$];
    logic       rx_done;

    apb_uart_bridge #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .baudrate   (BAUD),
        .clk_frec   (FREQ)
    ) dut (
        .clk     (clk),
        .arstn   (arstn),
        .rx      (rx),
        .tx      (tx),
        .paddr   (paddr),
        .pprot   (pprot),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] status_of(input int n);
        if (n == DEPTH)     return 32'h8;
        if (n == DEPTH - 1) return 32'h4;
        if (n == 0)         return 32'h2;
        if (n == 1)         return 32'h1;
        return 32'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] off, input logic [7:0] wdata,
                                 output logic [31:0] rdata, output logic err, output logic rdy);
        @(posedge clk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = BASE + off;
        pwdata  = {24'($urandom), wdata};
        pprot   = 3'($urandom);
        pstrb   = 4'($urandom);
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rdata = prdata;
        err   = pslverr;
        rdy   = pready;
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] off, input logic [31:0] exp, input logic exp_err, input string tag);
        logic [31:0] d;
        logic e, r;
        applyStimulus(1'b0, off, 8'h0, d, e, r);
        checkOutput({tag, "_data"}, d, exp);
        checkOutput({tag, "_err"}, 32'(e), 32'(exp_err));
        checkOutput({tag, "_ready"}, 32'(r), 32'd1);
    endtask

    task automatic apb_write(input logic [31:0] off, input logic [7:0] data, input logic exp_err, input string tag);
        logic [31:0] d;
        logic e, r;
        applyStimulus(1'b1, off, data, d, e, r);
        checkOutput({tag, "_err"}, 32'(e), 32'(exp_err));
        checkOutput({tag, "_ready"}, 32'(r), 32'd1);
    endtask

    task automatic apb_poll(input logic [31:0] off, output logic [31:0] d);
        logic e, r;
        applyStimulus(1'b0, off, 8'h0, d, e, r);
        checkOutput("poll_err", 32'(e), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (DIV) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (DIV) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int waited;
        waited = 0;
        while (tx_got.size() < n && waited < budget) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("tx_frame_count", 32'(tx_got.size()), 32'(n));
        repeat (DIV) @(posedge clk);
    endtask

    // Line-level observer of tx: decodes each frame by sampling at mid-bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (DIV / 2) @(posedge clk);
            #1 checkOutput("tx_start_bit", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                #1 b[i] = tx;
            end
            repeat (DIV) @(posedge clk);
            #1 checkOutput("tx_stop_bit", 32'(tx), 32'd1);
            tx_got.push_back(b);
        end
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int sent, got, t0, low_cycles, n;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_pready", 32'(pready), 32'd0);
        checkOutput("reset_prdata", prdata, 32'd0);
        checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
        arstn = 1'b1;

        psel = 1'b1; paddr = BASE; #1;
        checkOutput("setup_pready", 32'(pready), 32'd0);
        checkOutput("setup_prdata", prdata, 32'd0);
        psel = 1'b0;

        apb_read(32'h0, 32'h2, 1'b0, "tx_status_reset");
        apb_read(32'h4, 32'h2, 1'b0, "rx_status_reset");
        repeat (2 * DIV) @(posedge clk);
        #1 checkOutput("tx_idle", 32'(tx), 32'd1);

        apb_read(32'hC, 32'h0, ERR_ON, "unmapped_read");
        apb_write(32'h20, 8'h11, ERR_ON, "unmapped_write");
        apb_write(32'h4, 8'h55, ERR_ON, "write_rx_status");
        apb_write(32'h8, 8'h66, ERR_ON, "write_rx_data");
        apb_read(32'h4, 32'h2, 1'b0, "rx_status_after_writes");
        apb_read(32'h8, 32'h0, ERR_ON, "rx_data_empty");
        apb_read(32'h0, 32'h2, 1'b0, "tx_status_after_writes");

        // Single byte, LSB first on the line.
        tx_got.delete();
        apb_write(32'h0, 8'hA5, 1'b0, "tx_write_a5");
        apb_read(32'h0, 32'h2, 1'b0, "tx_status_after_pop");
        wait_tx(1, 20 * DIV);
        checkOutput("tx_byte_a5", 32'(tx_got[0]), 32'hA5);

        // Fill TX while the first frame is still on the line; the 18th byte overflows.
        tx_got.delete();
        tx_exp.delete();
        for (int k = 1; k <= 18; k++) begin
            b = 8'($urandom_range(0, 255));
            apb_write(32'h0, b, (k == 18) ? ERR_ON : 1'b0, "tx_fill_write");
            if (k <= 17) tx_exp.push_back(b);
            apb_read(32'h0, status_of((k - 1 > DEPTH) ? DEPTH : k - 1), 1'b0, "tx_fill_status");
        end
        wait_tx(17, 20 * 17 * DIV);
        for (int i = 0; i < 17 && i < tx_got.size(); i++)
            checkOutput("tx_fill_byte", 32'(tx_got[i]), 32'(tx_exp[i]));

        // RX: 17 frames without reading; the last one overruns.
        rx_model.delete();
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(100 + i), 1'b1);
            if (rx_model.size() < DEPTH) rx_model.push_back(8'(100 + i));
            apb_read(32'h4, status_of(rx_model.size()), 1'b0, "rx_fill_status");
        end
        while (rx_model.size() > 0) begin
            apb_read(32'h8, 32'(rx_model.pop_front()), 1'b0, "rx_fill_data");
        end
        apb_read(32'h4, 32'h2, 1'b0, "rx_drained_status");
        apb_read(32'h8, 32'h0, ERR_ON, "rx_drained_data");

        // 64 bytes with flow control on TX status.
        tx_got.delete();
        sent = 0;
        t0 = 0;
        while (sent < 64 && t0 < 20000) begin
            apb_poll(32'h0, d);
            if (d != 32'h8) begin
                apb_write(32'h0, 8'(sent), 1'b0, "tx_flow_write");
                sent++;
            end
            t0++;
        end
        wait_tx(64, 20 * 64 * DIV);
        for (int i = 0; i < 64 && i < tx_got.size(); i++)
            checkOutput("tx_flow_byte", 32'(tx_got[i]), 32'(i));

        // Concurrent random RX and TX traffic.
        tx_got.delete();
        rx_src.delete();
        tx_exp.delete();
        for (int i = 0; i < 64; i++) begin
            rx_src.push_back(8'($urandom_range(0, 255)));
            tx_exp.push_back(8'($urandom_range(0, 255)));
        end
        rx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) send_frame(rx_src[i], 1'b1);
                rx_done = 1'b1;
            end
            begin
                sent = 0;
                got  = 0;
                t0   = 0;
                while ((sent < 64 || got < 64) && t0 < 8000) begin
                    t0++;
                    if (sent < 64) begin
                        apb_poll(32'h0, d);
                        if (d != 32'h8) begin
                            apb_write(32'h0, tx_exp[sent], 1'b0, "cc_tx_write");
                            sent++;
                        end
                    end
                    apb_poll(32'h4, d);
                    if (d == 32'h8) n = DEPTH;
                    else if (rx_done && d != 32'h2) n = 1;
                    else n = 0;
                    for (int j = 0; j < n && got < 64; j++) begin
                        apb_read(32'h8, 32'(rx_src[got]), 1'b0, "cc_rx_data");
                        got++;
                    end
                end
                checkOutput("cc_all_transfers", 32'(sent + got), 32'd128);
            end
        join
        wait_tx(64, 20 * 64 * DIV);
        for (int i = 0; i < 64 && i < tx_got.size(); i++)
            checkOutput("cc_tx_byte", 32'(tx_got[i]), 32'(tx_exp[i]));
        apb_read(32'h4, 32'h2, 1'b0, "cc_rx_final_status");

        // Glitch shorter than half a bit, then a framing error, then a good frame.
        @(posedge clk); #1 rx = 1'b0;
        repeat (DIV / 2 - 3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        apb_read(32'h4, 32'h2, 1'b0, "glitch_status");
        send_frame(8'h3C, 1'b0);
        repeat (2 * DIV) @(posedge clk);
        apb_read(32'h4, 32'h2, 1'b0, "framing_error_status");
        send_frame(8'h5A, 1'b1);
        apb_read(32'h4, 32'h1, 1'b0, "recovery_status");
        apb_read(32'h8, 32'h5A, 1'b0, "recovery_data");
        apb_read(32'h8, 32'h0, ERR_ON, "recovery_empty_read");

        // Reset in the middle of a frame aborts TX and flushes both FIFOs.
        send_frame(8'h77, 1'b1);
        apb_read(32'h4, 32'h1, 1'b0, "pre_reset_rx_status");
        apb_write(32'h0, 8'h00, 1'b0, "pre_reset_tx0");
        apb_write(32'h0, 8'h00, 1'b0, "pre_reset_tx1");
        repeat (3 * DIV) @(posedge clk);
        #1 checkOutput("pre_reset_tx_low", 32'(tx), 32'd0);
        arstn = 1'b0;
        #1 checkOutput("reset_abort_tx", 32'(tx), 32'd1);
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        apb_read(32'h0, 32'h2, 1'b0, "post_reset_tx_status");
        apb_read(32'h4, 32'h2, 1'b0, "post_reset_rx_status");
        low_cycles = 0;
        repeat (12 * DIV) begin
            @(posedge clk);
            #1 if (tx !== 1'b1) low_cycles++;
        end
        checkOutput("post_reset_tx_quiet", 32'(low_cycles), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
